instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, 8, SHALL set program address width (program depth 2^ADDR_W words of 80 bits).
REQ-002 clk  in  1  SHALL be the single clock; all logic on rising edge.
REQ-003 rst  in  1  SHALL be synchronous, active-high reset.
REQ-004 prog_wr_en  in  1  SHALL be the host program-word write strobe.
REQ-005 prog_wr_addr  in  ADDR_W  SHALL be the program-word write address.
REQ-006 prog_wr_data  in  80  SHALL be the program word: [79:77] opcode, [76:70] count, [69:64] reserved, [63:32] addr, [31:0] data.
REQ-007 prog_len  in  ADDR_W+1  SHALL be the number of valid program words, sampled on run_start.
REQ-008 run_start  in  1  SHALL be the single-cycle request to start execution at address 0.
REQ-009 loop_en  in  1  SHALL, when high at end of program, wrap to address 0 instead of halting.
REQ-010 en_pc  in  1  SHALL be the fetch/advance request from the control FSM.
REQ-011 done_instr  in  1  SHALL be the instruction-retired pulse from the control FSM.
REQ-012 opcode  out  3  SHALL be the current instruction opcode.
REQ-013 count  out  7  SHALL be the current instruction repeat count.
REQ-014 axi_addr  out  32  SHALL be the current instruction AXI address.
REQ-015 axi_data  out  32  SHALL be the current instruction write/compare data.
REQ-016 pc  out  ADDR_W  SHALL be the address of the next word to fetch.
REQ-017 busy  out  1  SHALL be high in RUN or DRAIN.
REQ-018 prog_done  out  1  SHALL pulse one cycle when the program finishes.
REQ-019 load_err  out  1  SHALL be a sticky flag for program writes rejected while busy.
REQ-020 instr_retired  out  16  SHALL count done_instr pulses during busy.

Function
REQ-021 States SHALL be IDLE, RUN, DRAIN.
REQ-022 IDLE: prog_wr_en SHALL write prog_wr_data to prog_wr_addr; run_start SHALL latch prog_len, clear pc, instr_retired and load_err, and go to RUN.
REQ-023 Write and run_start in the same IDLE cycle SHALL both take effect; the written word is visible to the first fetch.
REQ-024 RUN: en_pc sampled high SHALL read the word at pc and increment pc by 1.
REQ-025 Fetch latency SHALL be exactly 2 clocks: outputs update on the 2nd rising edge after the en_pc cycle and hold until the next update.
REQ-026 End condition SHALL be en_pc with pc >= latched prog_len, or a fetched word with opcode 3'b111 (HALT).
REQ-027 At end with loop_en low: outputs SHALL be forced to NOP (all zero) at the normal update edge; state goes to DRAIN; pc is not incremented.
REQ-028 At end with loop_en high and prog_len != 0: the fetch SHALL be redirected to address 0 (pc becomes 1) with no NOP inserted; a HALT opcode always halts regardless of loop_en.
REQ-029 DRAIN: en_pc SHALL be ignored; the first done_instr SHALL return to IDLE and pulse prog_done that same cycle.
REQ-030 IDLE and DRAIN: opcode/count/axi_addr/axi_data SHALL read zero so the FSM sees only NOPs.
REQ-031 prog_len = 0 SHALL treat the first en_pc as end, regardless of loop_en.
REQ-032 prog_wr_en while busy SHALL be ignored and set load_err; load_err holds until rst or run_start.
REQ-033 run_start while busy SHALL be ignored.
REQ-034 instr_retired SHALL increment on done_instr while busy, saturating at 16'hFFFF.
REQ-035 pc SHALL wrap modulo 2^ADDR_W when prog_len = 2^ADDR_W.

Reset
REQ-036 rst SHALL force IDLE, pc=0, all instruction outputs 0, busy=0, prog_done=0, load_err=0, instr_retired=0, cancel any in-flight fetch; program memory contents are not cleared.

Verification
REQ-037 Load 3 words (opcodes 001,010,011, count 5), prog_len=3, run_start; en_pc every fetch -> fields valid exactly 2 clocks after each en_pc; 4th en_pc -> NOP, DRAIN; done_instr -> prog_done pulse, instr_retired=4.
REQ-038 Word 1 opcode 111 among 3 -> 2nd fetch yields NOP, DRAIN, pc stays 1.
REQ-039 loop_en=1, prog_len=2 -> fetch sequence 0,1,0,1; pc sequence 1,2,1,2; busy stays high.
REQ-040 prog_wr_en during RUN -> memory unchanged (read back after next run), load_err=1 until run_start.
REQ-041 prog_len=0, run_start, en_pc -> NOP output, DRAIN; done_instr -> prog_done.
REQ-042 rst asserted one cycle after en_pc in RUN -> next cycle IDLE, outputs 0, no field update from the cancelled fetch.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: host-loaded program memory feeding the control FSM
// through a two-stage fetch pipeline; loops back to word 0 or drains at end of program.
module instr_fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_wr_en,
  input  logic [ADDR_W-1:0] prog_wr_addr,
  input  logic [79:0]       prog_wr_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              run_start,
  input  logic              loop_en,
  input  logic              en_pc,
  input  logic              done_instr,
  output logic [2:0]        opcode,
  output logic [6:0]        count,
  output logic [31:0]       axi_addr,
  output logic [31:0]       axi_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              prog_done,
  output logic              load_err,
  output logic [15:0]       instr_retired
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = 74;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W:0]     r_len;
  logic                r_vld_p0;
  logic                r_end_p0;
  logic [WORD_W-1:0]   r_word_p0;
  logic [WORD_W-1:0]   r_word_p1;
  logic                r_prog_done;
  logic                r_load_err;
  logic [15:0]         r_retired;

  logic                w_busy;
  logic                w_wr;
  logic                w_start;
  logic                w_at_end;
  logic                w_wrap;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [WORD_W-1:0]   w_word;
  logic                w_halt;
  logic                w_end;
  logic                w_end_pend;
  logic                w_fetch;
  logic                w_unused;

  // Reserved bits [69:64] are dropped; stored word is {opcode, count, addr, data}.
  assign w_unused   = ^prog_wr_data[69:64];

  assign w_busy     = (r_state != S_IDLE);
  assign w_wr       = (r_state == S_IDLE) && prog_wr_en;
  assign w_start    = (r_state == S_IDLE) && run_start;

  assign w_at_end   = ({1'b0, r_pc} >= r_len);
  assign w_wrap     = w_at_end && loop_en && (r_len != '0);
  assign w_rd_addr  = w_wrap ? '0 : r_pc;
  assign w_word     = r_mem[w_rd_addr];
  // HALT only counts for a word that is actually part of the program.
  assign w_halt     = (w_word[73:71] == 3'b111) && (!w_at_end || w_wrap);
  assign w_end      = (w_at_end && !w_wrap) || w_halt;
  // While the end-of-program NOP is in flight, further fetches are held off.
  assign w_end_pend = r_vld_p0 && r_end_p0;
  assign w_fetch    = (r_state == S_RUN) && en_pc && !w_end_pend;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[prog_wr_addr] <= {prog_wr_data[79:70], prog_wr_data[63:0]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (run_start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_end_pend) w_state_nxt = S_DRAIN;
      S_DRAIN: if (done_instr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prog_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prog_done <= (r_state == S_DRAIN) && done_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_load_err <= 1'b0;
      r_retired  <= '0;
    end else begin
      if (w_start) begin
        r_pc <= '0;
      end else if (w_fetch && !w_end) begin
        r_pc <= w_rd_addr + 1'b1;
      end

      if (w_start) begin
        r_load_err <= 1'b0;
      end else if (w_busy && prog_wr_en) begin
        r_load_err <= 1'b1;
      end

      if (w_start) begin
        r_retired <= '0;
      end else if (w_busy && done_instr) begin
        r_retired <= sat_inc16(r_retired);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_len <= prog_len;
    end
  end

  // Stage p0: memory word captured on the en_pc sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_end_p0  <= w_end;
      r_word_p0 <= w_end ? '0 : w_word;
    end
  end

  // Stage p1: instruction fields presented to the control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_p1 <= '0;
    end else if (r_vld_p0) begin
      r_word_p1 <= r_word_p0;
    end
  end

  assign opcode        = r_word_p1[73:71];
  assign count         = r_word_p1[70:64];
  assign axi_addr      = r_word_p1[63:32];
  assign axi_data      = r_word_p1[31:0];
  assign pc            = r_pc;
  assign busy          = w_busy;
  assign prog_done     = r_prog_done;
  assign load_err      = r_load_err;
  assign instr_retired = r_retired;

endmodule
